// File: rtl/scratch_fill_controller.sv
// Round-robin drain of NUM_CH read buffers into a ring-addressed scratchpad, one word per cycle.
// Optional macro SCRATCH_FILL_BURST_HOLD_EN: a granted channel keeps the grant while its valid stays high.
module scratch_fill_controller #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   fill_len,
  input  logic              scratch_write_en,
  input  logic [NUM_CH-1:0] valid,
  output logic [NUM_CH-1:0] rd_ack,
  output logic              write_in_scratch,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_ch,
  output logic              cnt,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [CH_W-1:0]   rr, rr_nxt;
  logic [CH_W-1:0]   last_ch, last_ch_nxt;
  logic              grant_any;
  logic [CH_W-1:0]   grant_ch;
  logic              hold_hit;
`ifdef SCRATCH_FILL_BURST_HOLD_EN
  logic              held, held_nxt;
`endif

  // Circular search for the first asserted valid at or after the rr pointer
  always_comb begin
    int unsigned idx;
    logic [CH_W-1:0] cidx;
    idx       = 0;
    cidx      = '0;
    grant_any = 1'b0;
    grant_ch  = rr;
    hold_hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cidx = CH_W'(idx);
      if (!grant_any && valid[cidx]) begin
        grant_any = 1'b1;
        grant_ch  = cidx;
      end
    end
`ifdef SCRATCH_FILL_BURST_HOLD_EN
    if (held && valid[last_ch]) begin
      grant_any = 1'b1;
      grant_ch  = last_ch;
      hold_hit  = 1'b1;
    end
`endif
  end

  // Next-state and Mealy outputs; reset masks the in-flight cycle's strobe
  always_comb begin
    state_nxt        = state;
    addr_nxt         = addr;
    remaining_nxt    = remaining;
    rr_nxt           = rr;
    last_ch_nxt      = last_ch;
`ifdef SCRATCH_FILL_BURST_HOLD_EN
    held_nxt         = held;
`endif
    write_in_scratch = 1'b0;
    rd_ack           = '0;
    wr_ch            = last_ch;
    busy             = 1'b0;
    done             = 1'b0;

    unique case (state)
      IDLE: begin
`ifdef SCRATCH_FILL_BURST_HOLD_EN
        held_nxt = 1'b0;
`endif
        if (start) begin
          if (fill_len == '0) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = (fill_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : fill_len;
            state_nxt     = RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (scratch_write_en && grant_any) begin
          write_in_scratch = 1'b1;
          rd_ack           = NUM_CH'(1) << grant_ch;
          wr_ch            = grant_ch;
          addr_nxt         = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
          remaining_nxt    = remaining - LEN_W'(1);
          last_ch_nxt      = grant_ch;
          if (!hold_hit)
            rr_nxt = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
`ifdef SCRATCH_FILL_BURST_HOLD_EN
          held_nxt = 1'b1;
`endif
          if (remaining == LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      write_in_scratch = 1'b0;
      rd_ack           = '0;
      wr_ch            = '0;
      busy             = 1'b0;
      done             = 1'b0;
    end
  end

  assign cnt     = write_in_scratch;
  assign wr_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      rr        <= '0;
      last_ch   <= '0;
`ifdef SCRATCH_FILL_BURST_HOLD_EN
      held      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      rr        <= rr_nxt;
      last_ch   <= last_ch_nxt;
`ifdef SCRATCH_FILL_BURST_HOLD_EN
      held      <= held_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_scratch_fill_controller.sv
// Scoreboard bench for scratch_fill_controller: directed scenarios followed by random traffic,
// each cycle's expected outputs queued by a reference model and checked by a separate monitor.
module tb_scratch_fill_controller;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] fill_len;
  logic       swe;
  logic [3:0] valid;
  logic [3:0] rd_ack;
  logic       write_in_scratch;
  logic [3:0] wr_addr;
  logic [1:0] wr_ch;
  logic       cnt;
  logic       busy;
  logic       done;

  scratch_fill_controller #(
    .NUM_CH(4), .CH_W(2), .DEPTH(16), .ADDR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fill_len(fill_len),
    .scratch_write_en(swe), .valid(valid), .rd_ack(rd_ack),
    .write_in_scratch(write_in_scratch), .wr_addr(wr_addr), .wr_ch(wr_ch),
    .cnt(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [3:0] ack;
    logic [1:0] ch;
    logic [3:0] addr;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: 0 idle, 1 filling, 2 done pulse
  int m_state = 0, m_addr = 0, m_rem = 0, m_rr = 0, m_last = 0;
  bit m_held  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input int len, input bit we, input logic [3:0] v);
    exp_t e;
    int   g;
    @(posedge clk);
    #1;
    rst = r; start = s; fill_len = 5'(len); swe = we; valid = v;
    e.wr = 1'b0; e.ack = 4'd0; e.ch = 2'(m_last); e.addr = 4'(m_addr);
    e.busy = (m_state != 0); e.done = (m_state == 2);
    if (r) begin
      e.busy = 1'b0; e.done = 1'b0; e.ch = 2'd0;
      m_state = 0; m_addr = 0; m_rem = 0; m_rr = 0; m_last = 0; m_held = 1'b0;
    end else begin
      case (m_state)
        0: begin
          m_held = 1'b0;
          if (s) begin
            if (len == 0) m_state = 2;
            else begin
              m_rem   = (len > DEPTH) ? DEPTH : len;
              m_state = 1;
            end
          end
        end
        1: if (we && v != 4'd0) begin
          g = -1;
`ifdef SCRATCH_FILL_BURST_HOLD_EN
          if (m_held && v[m_last]) g = m_last;
`endif
          for (int i = 0; i < NUM_CH && g < 0; i++) begin
            if (v[(m_rr + i) % NUM_CH]) begin
              g    = (m_rr + i) % NUM_CH;
              m_rr = (g + 1) % NUM_CH;
            end
          end
          e.wr   = 1'b1;
          e.ack  = 4'(1 << g);
          e.ch   = 2'(g);
          m_addr = (m_addr + 1) % DEPTH;
          m_rem  = m_rem - 1;
          m_last = g;
          m_held = 1'b1;
          if (m_rem == 0) m_state = 2;
        end
        default: m_state = 0;
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_in_scratch", 32'(write_in_scratch), 32'(e.wr));
        chk("cnt", 32'(cnt), 32'(e.wr));
        chk("rd_ack", 32'(rd_ack), 32'(e.ack));
        chk("wr_ch", 32'(wr_ch), 32'(e.ch));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; fill_len = 5'd0; swe = 1'b0; valid = 4'd0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 4'b0000);
    // basic fill of 3 from channel 0
    step(0, 1, 3, 1, 4'b0001);
    repeat (5) step(0, 0, 0, 1, 4'b0001);
    // round-robin over all channels
    step(0, 1, 6, 1, 4'b1111);
    repeat (8) step(0, 0, 0, 1, 4'b1111);
    // stalls via scratch_write_en
    step(0, 1, 4, 0, 4'b0101);
    for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2 == 0), 4'b0101);
    // zero-length fill and starts during a fill
    step(0, 1, 0, 1, 4'b1111);
    step(0, 0, 0, 1, 4'b1111);
    step(0, 0, 0, 0, 4'b0000);
    step(0, 1, 5, 1, 4'b0011);
    step(0, 1, 9, 1, 4'b0011);
    step(0, 1, 9, 1, 4'b0011);
    repeat (6) step(0, 0, 0, 1, 4'b0011);
    // two back-to-back fills of 10 wrap the ring
    step(1, 0, 0, 0, 4'b0000);
    step(0, 1, 10, 1, 4'b1010);
    repeat (11) step(0, 0, 0, 1, 4'b1010);
    step(0, 1, 10, 1, 4'b1001);
    repeat (11) step(0, 0, 0, 1, 4'b1001);
    // reset after 2 of 5 writes, then a fresh fill of 2
    step(0, 1, 5, 1, 4'b0010);
    repeat (2) step(0, 0, 0, 1, 4'b0010);
    step(1, 0, 0, 1, 4'b0010);
    step(0, 1, 2, 1, 4'b0010);
    repeat (3) step(0, 0, 0, 1, 4'b0010);
    // oversize length clamps to DEPTH
    step(0, 1, 31, 1, 4'b1111);
    repeat (18) step(0, 0, 0, 1, 4'b1111);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 4'($urandom));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
